// File: rtl/fb_double_buffer.sv
// Double-buffered frame store: the VGA scan reads the front bank while
// pixel writes and CLEAR fills target the back bank; SWAP flips at frame end.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   h_pxl_count/v_pxl_count  current scan position from the timing stage
//   color                    registered RGB for the scan position (1 cycle)
//   wr_valid/wr_ready        pixel write handshake (wr_x, wr_y, wr_color)
//   cmd_valid/cmd_ready      command handshake, cmd_op 0=CLEAR 1=SWAP
//   clear_color              fill value latched when CLEAR is accepted
//   front_sel                bank currently displayed
//   swap_done                one-cycle pulse after the bank flip
module fb_double_buffer #(
  parameter int H_RES             = 200,
  parameter int V_RES             = 150,
  parameter int SCALE_SHIFT       = 2,
  parameter int H_WHOLE_LINE_PXL  = 1056,
  parameter int V_WHOLE_FRAME_PXL = 628,
  parameter int H_NUM_BITS        = 11,
  parameter int V_NUM_BITS        = 10,
  parameter int CHANNEL_BITS      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [H_NUM_BITS-1:0]     h_pxl_count,
  input  logic [V_NUM_BITS-1:0]     v_pxl_count,
  output logic [3*CHANNEL_BITS-1:0] color,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [7:0]                wr_x,
  input  logic [7:0]                wr_y,
  input  logic [3*CHANNEL_BITS-1:0] wr_color,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_op,
  input  logic [3*CHANNEL_BITS-1:0] clear_color,
  output logic                      front_sel,
  output logic                      swap_done
);

  localparam int CW    = 3 * CHANNEL_BITS;
  localparam int DEPTH = H_RES * V_RES;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SWAP_WAIT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0] bank0 [DEPTH];
  logic [CW-1:0] bank1 [DEPTH];

  logic          idle;
  logic          wr_fire;
  logic          cmd_fire;
  logic          frame_end;
  logic          swap_now;

  logic [H_NUM_BITS-1:0] h_s;
  logic [V_NUM_BITS-1:0] v_s;
  logic                  rd_hit;
  logic [AW-1:0]         rd_addr;

  logic                  wr_hit;
  logic [AW-1:0]         wr_addr;

  logic [AW-1:0]         clear_addr;
  logic [CW-1:0]         clear_val;

  logic                  mem_we;
  logic [AW-1:0]         mem_wa;
  logic [CW-1:0]         mem_wd;

  assign idle      = (state == IDLE);
  assign wr_ready  = idle;
  assign cmd_ready = idle;
  assign wr_fire   = wr_valid && idle;
  assign cmd_fire  = cmd_valid && idle;

  assign frame_end =
    (h_pxl_count == H_NUM_BITS'(H_WHOLE_LINE_PXL - 1)) &&
    (v_pxl_count == V_NUM_BITS'(V_WHOLE_FRAME_PXL - 1));

  // Flip only from SWAP_WAIT, so a SWAP accepted on a frame_end
  // cycle waits for the following frame_end.
  assign swap_now = (state == SWAP_WAIT) && frame_end;

  assign h_s = h_pxl_count >> SCALE_SHIFT;
  assign v_s = v_pxl_count >> SCALE_SHIFT;

  assign rd_hit = (32'(h_s) < 32'(H_RES)) &&
                  (32'(v_s) < 32'(V_RES));
  assign rd_addr =
    AW'(32'(v_s) * 32'(H_RES) + 32'(h_s));

  assign wr_hit = (32'(wr_x) < 32'(H_RES)) &&
                  (32'(wr_y) < 32'(V_RES));
  assign wr_addr =
    AW'(32'(wr_y) * 32'(H_RES) + 32'(wr_x));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (cmd_fire)
          state_nx = cmd_op ? SWAP_WAIT : CLEAR;
      end
      CLEAR: begin
        if (clear_addr == LAST)
          state_nx = IDLE;
      end
      SWAP_WAIT: begin
        if (frame_end)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      front_sel  <= 1'b0;
      swap_done  <= 1'b0;
      clear_addr <= '0;
      clear_val  <= '0;
    end else begin
      state     <= state_nx;
      swap_done <= swap_now;
      if (swap_now)
        front_sel <= ~front_sel;
      if (cmd_fire && !cmd_op) begin
        clear_addr <= '0;
        clear_val  <= clear_color;
      end else if (state == CLEAR) begin
        clear_addr <= clear_addr + 1'b1;
      end
    end
  end

  // Single back-bank write port: the fill owns it during CLEAR,
  // otherwise an accepted in-range pixel write. A write accepted
  // together with a command lands first because the command only
  // acts from the next cycle on.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = wr_addr;
    mem_wd = wr_color;
    if (state == CLEAR) begin
      mem_we = 1'b1;
      mem_wa = clear_addr;
      mem_wd = clear_val;
    end else if (wr_fire && wr_hit) begin
      mem_we = 1'b1;
    end
    if (rst)
      mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (front_sel)
        bank0[mem_wa] <= mem_wd;
      else
        bank1[mem_wa] <= mem_wd;
    end
  end

  // front_sel is already flipped on the cycle after frame_end, so
  // (0,0) of the next frame comes from the new bank.
  always_ff @(posedge clk) begin
    if (rst)
      color <= '0;
    else if (!rd_hit)
      color <= '0;
    else if (front_sel)
      color <= bank1[rd_addr];
    else
      color <= bank0[rd_addr];
  end

endmodule

// File: doc/fb_double_buffer.md
FB_DOUBLE_BUFFER -- requirements
Module: fb_double_buffer

Interface
REQ-001 SHALL have parameter H_RES, default 200, meaning stored frame width in pixels.
REQ-002 SHALL have parameter V_RES, default 150, meaning stored frame height in pixels.
REQ-003 SHALL have parameter SCALE_SHIFT, default 2, meaning the display-to-stored pixel scale, log2.
REQ-004 SHALL have parameter H_WHOLE_LINE_PXL, default 1056, meaning total horizontal count per line.
REQ-005 SHALL have parameter V_WHOLE_FRAME_PXL, default 628, meaning total lines per frame.
REQ-006 SHALL have parameters H_NUM_BITS (default 11), V_NUM_BITS (default 10) and CHANNEL_BITS (default 2).
REQ-007 SHALL have port clk, input, width 1: the single clock; all logic on rising edge.
REQ-008 SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-009 SHALL have ports h_pxl_count / v_pxl_count, inputs, widths H_NUM_BITS / V_NUM_BITS: the current scan position from the VGA timing stage.
REQ-010 SHALL have port color, output, width 3*CHANNEL_BITS: RGB for the scan position, ordered R in the MSBs down to B in the LSBs.
REQ-011 SHALL have ports wr_valid (in, 1), wr_ready (out, 1), wr_x (in, 8), wr_y (in, 8) and wr_color (in, 3*CHANNEL_BITS): the pixel write port into the back buffer.
REQ-012 SHALL have ports cmd_valid (in, 1), cmd_ready (out, 1) and cmd_op (in, 1): commands, where 0 = CLEAR and 1 = SWAP.
REQ-013 SHALL have port clear_color, input, width 3*CHANNEL_BITS: the fill value, sampled when a CLEAR command is accepted.
REQ-014 SHALL have ports front_sel (out, 1), meaning the bank being displayed, and swap_done (out, 1), a one-cycle pulse when a swap takes effect.

Function
REQ-015 SHALL hold two banks of H_RES*V_RES words, each 3*CHANNEL_BITS wide; the display reads bank front_sel and writes go to bank !front_sel.
REQ-016 SHALL register color exactly 1 cycle after the scan position is presented, using read address (v>>SCALE_SHIFT)*H_RES + (h>>SCALE_SHIFT).
REQ-017 SHALL output color = 0 when (h>>SCALE_SHIFT) >= H_RES or (v>>SCALE_SHIFT) >= V_RES, with the same 1-cycle latency.
REQ-018 SHALL implement states IDLE, CLEAR and SWAP_WAIT.
REQ-019 SHALL drive wr_ready = cmd_ready = (state == IDLE).
REQ-020 SHALL, in IDLE, write wr_color on a wr_valid&&wr_ready cycle to address wr_y*H_RES + wr_x; a write with wr_x >= H_RES or wr_y >= V_RES SHALL be accepted and discarded.
REQ-021 SHALL, when a write and a command are accepted in the same cycle, commit the write to the back bank as it stood before the command.
REQ-022 SHALL, on accepting CLEAR in IDLE, enter CLEAR and write the latched clear_color to back-bank addresses 0..H_RES*V_RES-1, one per cycle, in ascending order; after the last address it SHALL return to IDLE on the next cycle (CLEAR lasts H_RES*V_RES cycles).
REQ-023 SHALL, on accepting SWAP in IDLE, enter SWAP_WAIT.
REQ-024 SHALL define frame_end as h_pxl_count == H_WHOLE_LINE_PXL-1 && v_pxl_count == V_WHOLE_FRAME_PXL-1.
REQ-025 SHALL, in SWAP_WAIT on a frame_end cycle, toggle front_sel, pulse swap_done the following cycle, and return to IDLE.
REQ-026 SHALL, when SWAP is accepted on a frame_end cycle itself, not swap until the next frame_end (no same-cycle swap).
REQ-027 SHALL read position (0,0) from the new front bank on the first cycle after the toggle, so no frame ever mixes banks.
REQ-028 SHALL not accept commands or writes outside IDLE, so CLEAR and SWAP never overlap.

Reset
REQ-029 SHALL, on rst high at any clock edge, set state to IDLE, front_sel to 0, color to 0 and swap_done to 0, and abandon any CLEAR or SWAP in progress.
REQ-030 SHALL leave memory contents unchanged by reset.
REQ-031 SHALL drive wr_ready and cmd_ready to 1 on the first cycle after rst deasserts.

Verification
REQ-032 Write test SHALL apply write (x=5, y=3, color 6'h2A) then SWAP, wait for swap_done, and scan h=20..23, v=12..15; color SHALL read 6'h2A one cycle later and 0 elsewhere.
REQ-033 Clear test SHALL issue CLEAR with clear_color=6'h15; wr_ready SHALL be low for exactly 30000 cycles, and after a SWAP every visible stored pixel SHALL read 6'h15.
REQ-034 Swap timing test SHALL issue SWAP mid-frame; front_sel SHALL toggle only at h=1055, v=627, swap_done SHALL pulse once, and a SWAP issued on the frame_end cycle SHALL wait one full frame.
REQ-035 Simultaneous test SHALL issue a write and SWAP in the same cycle; the written pixel SHALL be visible after the swap.
REQ-036 Bounds test SHALL write x=200, y=0; it SHALL be accepted with no memory change, and scan positions h >= 800 SHALL give color 0.
REQ-037 Reset test SHALL assert rst 100 cycles into a CLEAR; state SHALL return to IDLE, front_sel SHALL be 0, and wr_ready SHALL be 1 on the next cycle after release.
